// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-image loader: FSM states, checksum and header sizes.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    HDR_LO  = 3'd0,
    HDR_HI  = 3'd1,
    DATA_LO = 3'd2,
    DATA_HI = 3'd3,
    CSUM    = 3'd4,
    RUN     = 3'd5,
    ERROR   = 3'd6
  } state_t;

  localparam int CSUM_WIDTH = 8;
  localparam int HDR_BYTES  = 2;

  // Modular 8-bit accumulation of one received byte into the running checksum.
  function automatic logic [CSUM_WIDTH-1:0] csum_add(input logic [CSUM_WIDTH-1:0] acc,
                                                     input logic [7:0]            data);
    return acc + data;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Instruction memory: one synchronous write port, one registered read port.
// The array itself has no reset; only the read register is cleared.
module imem_ram #(
  parameter int width       = 16,
  parameter int iaddr_width = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [iaddr_width-1:0] waddr,
  input  logic [width-1:0]       wdata,
  input  logic [iaddr_width-1:0] raddr,
  output logic [width-1:0]       rdata
);

  logic [width-1:0] mem_r [0:(1<<iaddr_width)-1];

  // Array write; contents persist across reset and reload.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read; a same-cycle write to raddr is not visible until the next read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= {width{1'b0}};
    end else begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a byte-serial image (count, words, checksum), writes it
// into instruction memory and releases the CPU from reset once the image checks out.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int width       = 16,
  parameter int iaddr_width = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  input  logic                   reload,
  input  logic [iaddr_width-1:0] iaddr,
  output logic [width-1:0]       idata,
  output logic                   cpu_reset,
  output logic                   loaded,
  output logic                   error
);

  localparam int unsigned DEPTH = 32'd1 << iaddr_width;

  state_t                  state_r;
  state_t                  next_state_s;
  logic [15:0]             count_r;
  logic [7:0]              low_byte_r;
  logic [iaddr_width-1:0]  waddr_r;
  logic [CSUM_WIDTH-1:0]   csum_r;
  logic                    cpu_reset_r;
  logic                    loaded_r;
  logic                    error_r;

  logic                    xfer_s;
  logic                    we_s;
  logic [15:0]             hdr_count_s;
  logic                    last_word_s;
  logic [width-1:0]        wdata_s;

  assign rx_ready    = (state_r != RUN) && (state_r != ERROR);
  assign xfer_s      = rx_valid && rx_ready;
  assign hdr_count_s = {rx_data, count_r[7:0]};
  assign last_word_s = ((32'(waddr_r) + 32'd1) == 32'(count_r));
  assign wdata_s     = width'({rx_data, low_byte_r});

  assign cpu_reset = cpu_reset_r;
  assign loaded    = loaded_r;
  assign error     = error_r;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= HDR_LO;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and memory write decision; reload overrides any byte in flight.
  always_comb begin
    next_state_s = state_r;
    we_s         = 1'b0;
    if (reload) begin
      next_state_s = HDR_LO;
    end else if (xfer_s) begin
      case (state_r)
        HDR_LO: next_state_s = HDR_HI;
        HDR_HI: begin
          if (hdr_count_s == 16'd0) begin
            next_state_s = CSUM;
          end else if (32'(hdr_count_s) > DEPTH) begin
            next_state_s = ERROR;
          end else begin
            next_state_s = DATA_LO;
          end
        end
        DATA_LO: next_state_s = DATA_HI;
        DATA_HI: begin
          we_s = 1'b1;
          if (last_word_s) begin
            next_state_s = CSUM;
          end else begin
            next_state_s = DATA_LO;
          end
        end
        CSUM: begin
          if (csum_add(csum_r, rx_data) == 8'h00) begin
            next_state_s = RUN;
          end else begin
            next_state_s = ERROR;
          end
        end
        default: next_state_s = state_r;
      endcase
    end else begin
      next_state_s = state_r;
    end
  end

  // Header count, low-byte holding, write address and checksum accumulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r    <= 16'd0;
      low_byte_r <= 8'd0;
      waddr_r    <= {iaddr_width{1'b0}};
      csum_r     <= {CSUM_WIDTH{1'b0}};
    end else if (reload) begin
      count_r    <= 16'd0;
      waddr_r    <= {iaddr_width{1'b0}};
      csum_r     <= {CSUM_WIDTH{1'b0}};
    end else if (xfer_s) begin
      csum_r <= csum_add(csum_r, rx_data);
      case (state_r)
        HDR_LO:  count_r[7:0]  <= rx_data;
        HDR_HI:  count_r[15:8] <= rx_data;
        DATA_LO: low_byte_r    <= rx_data;
        DATA_HI: waddr_r       <= waddr_r + iaddr_width'(1);
        default: waddr_r       <= waddr_r;
      endcase
    end
  end

  // Status outputs registered from the next state so they track the state register exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_reset_r <= 1'b1;
      loaded_r    <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      cpu_reset_r <= (next_state_s != RUN);
      loaded_r    <= (next_state_s == RUN);
      error_r     <= (next_state_s == ERROR);
    end
  end

  imem_ram #(
    .width       (width),
    .iaddr_width (iaddr_width)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (we_s),
    .waddr (waddr_r),
    .wdata (wdata_s),
    .raddr (iaddr),
    .rdata (idata)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: scenario tasks plus a read-back scoreboard.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        reload;
  logic [9:0]  iaddr;
  logic [15:0] idata;
  logic        cpu_reset;
  logic        loaded;
  logic        error;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [9:0]  a;
    logic [15:0] d;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] model_mem [0:1023];

  imem_loader dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .reload    (reload),
    .iaddr     (iaddr),
    .idata     (idata),
    .cpu_reset (cpu_reset),
    .loaded    (loaded),
    .error     (error)
  );

  always #5 clk = ~clk;

  // All tasks start and end at a falling edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic expect_word(input logic [9:0] a);
    exp_t e;
    e.a = a;
    e.d = model_mem[a];
    sb_q.push_back(e);
  endtask

  task automatic drain_scoreboard(input string tag);
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      iaddr = e.a;
      @(negedge clk);
      checks++;
      if (idata !== e.d) begin
        failures++;
        $display("FAIL %s idata[%0d] got=%h exp=%h", tag, e.a, idata, e.d);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; reload = 1'b0; iaddr = 10'd0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({rx_ready, cpu_reset, loaded, error} !== 4'b1100) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=1100", {rx_ready, cpu_reset, loaded, error});
    end
    checks++;
    if (idata !== 16'h0000) begin
      failures++;
      $display("FAIL reset_idata got=%h exp=0000", idata);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load();
    logic [7:0] img [7] = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h40};
    for (int i = 0; i < 6; i++) send_byte(img[i]);
    model_mem[0] = 16'h1234; expect_word(10'd0);
    model_mem[1] = 16'hABCD; expect_word(10'd1);
    checks++;
    if (cpu_reset !== 1'b1 || loaded !== 1'b0) begin
      failures++;
      $display("FAIL load_pre_csum cpu_reset=%b loaded=%b exp 1/0", cpu_reset, loaded);
    end
    send_byte(img[6]);
    checks++;
    if ({loaded, cpu_reset, error, rx_ready} !== 4'b1000) begin
      failures++;
      $display("FAIL load_run flags got=%b exp=1000", {loaded, cpu_reset, error, rx_ready});
    end
    drain_scoreboard("load");
  endtask

  task automatic test_bad_csum();
    logic [7:0] img [7] = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h41};
    pulse_reload();
    checks++;
    if ({rx_ready, cpu_reset, loaded} !== 3'b110) begin
      failures++;
      $display("FAIL reload_from_run got=%b exp=110", {rx_ready, cpu_reset, loaded});
    end
    for (int i = 0; i < 7; i++) send_byte(img[i]);
    checks++;
    if ({error, cpu_reset, rx_ready, loaded} !== 4'b1100) begin
      failures++;
      $display("FAIL bad_csum flags got=%b exp=1100", {error, cpu_reset, rx_ready, loaded});
    end
    // A byte offered in ERROR must be ignored.
    send_byte(8'h55);
    checks++;
    if (error !== 1'b1) begin
      failures++;
      $display("FAIL error_sticky got=%b exp=1", error);
    end
    pulse_reload();
    checks++;
    if ({rx_ready, error, cpu_reset} !== 3'b101) begin
      failures++;
      $display("FAIL reload_from_error got=%b exp=101", {rx_ready, error, cpu_reset});
    end
  endtask

  task automatic test_oversize();
    send_byte(8'h01);
    send_byte(8'h04);
    checks++;
    if ({error, rx_ready, cpu_reset} !== 3'b101) begin
      failures++;
      $display("FAIL oversize flags got=%b exp=101", {error, rx_ready, cpu_reset});
    end
    expect_word(10'd0);
    expect_word(10'd1);
    drain_scoreboard("oversize");
    pulse_reload();
  endtask

  task automatic test_empty();
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    checks++;
    if ({loaded, cpu_reset, error} !== 3'b100) begin
      failures++;
      $display("FAIL empty_run got=%b exp=100", {loaded, cpu_reset, error});
    end
    expect_word(10'd0);
    expect_word(10'd1);
    drain_scoreboard("empty");
  endtask

  task automatic test_reload_priority();
    pulse_reload();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h34);
    // Reload and a valid byte together: the byte must be dropped.
    reload = 1'b1; rx_valid = 1'b1; rx_data = 8'h12;
    @(negedge clk);
    reload = 1'b0; rx_valid = 1'b0;
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    model_mem[0] = 16'h2211; expect_word(10'd0);
    expect_word(10'd1);
    send_byte(8'hCC);
    checks++;
    if ({loaded, error} !== 2'b10) begin
      failures++;
      $display("FAIL reload_priority got=%b exp=10", {loaded, error});
    end
    drain_scoreboard("reload_priority");
  endtask

  task automatic test_random_valid();
    logic [7:0] img [7] = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h40};
    pulse_reload();
    for (int i = 0; i < 7; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(negedge clk);
      end
      send_byte(img[i]);
    end
    model_mem[0] = 16'h1234; expect_word(10'd0);
    model_mem[1] = 16'hABCD; expect_word(10'd1);
    checks++;
    if ({loaded, cpu_reset, error} !== 3'b100) begin
      failures++;
      $display("FAIL random_valid got=%b exp=100", {loaded, cpu_reset, error});
    end
    drain_scoreboard("random_valid");
  endtask

  task automatic test_reset_midload();
    pulse_reload();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h34);
    send_byte(8'h12);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({rx_ready, cpu_reset, loaded, error} !== 4'b1100) begin
      failures++;
      $display("FAIL midload_reset got=%b exp=1100", {rx_ready, cpu_reset, loaded, error});
    end
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hEF);
    send_byte(8'hBE);
    send_byte(8'h52);
    model_mem[0] = 16'hBEEF; expect_word(10'd0);
    expect_word(10'd1);
    checks++;
    if ({loaded, error} !== 2'b10) begin
      failures++;
      $display("FAIL fresh_image got=%b exp=10", {loaded, error});
    end
    drain_scoreboard("reset_midload");
  endtask

  task automatic test_rw_collision();
    logic [15:0] old_word;
    old_word = model_mem[0];
    pulse_reload();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h78);
    iaddr = 10'd0;
    send_byte(8'h56);
    checks++;
    if (idata !== old_word) begin
      failures++;
      $display("FAIL collision_old idata got=%h exp=%h", idata, old_word);
    end
    model_mem[0] = 16'h5678;
    @(negedge clk);
    checks++;
    if (idata !== 16'h5678) begin
      failures++;
      $display("FAIL collision_new idata got=%h exp=5678", idata);
    end
    send_byte(8'h31);
    checks++;
    if ({loaded, error} !== 2'b10) begin
      failures++;
      $display("FAIL collision_run got=%b exp=10", {loaded, error});
    end
    expect_word(10'd1);
    drain_scoreboard("collision");
  endtask

  initial begin
    test_reset();
    test_load();
    test_bad_csum();
    test_oversize();
    test_empty();
    test_reload_priority();
    test_random_valid();
    test_reset_midload();
    test_rw_collision();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
